accumulator_signed: RTL and testbench
=====================================

# accumulator_signed

Signed block accumulator that sits directly downstream of the signed sequential multiplier. It consumes a stream of signed products over a valid/accept handshake, sums `COUNT` consecutive products into a saturating accumulator, and presents the block sum over a second valid/accept handshake. The typical use is to form dot products from the multiplier's output.

## Interface
- `DATA_WIDTH_IN`, default 16: width of each signed input product.
- `COUNT`, default 4: number of products per block; must be at least 1.
- `DATA_WIDTH_OUT`, default `DATA_WIDTH_IN + clog2(COUNT)`: width of the signed sum. A narrower value enables saturation.
- `i_clk`  input  1  clock; all state updates on the rising edge.
- `i_nrst`  input  1  reset, asynchronous and active-low.
- `i_data`  input  `DATA_WIDTH_IN`  signed product to accumulate.
- `i_valid`  input  1  `i_data` is valid.
- `o_accept`  output  1  block can take `i_data` this cycle.
- `i_clear`  input  1  synchronous abort of the current block.
- `o_data`  output  `DATA_WIDTH_OUT`  signed block sum.
- `o_overflow`  output  1  saturation occurred in this block; qualified by `o_valid`.
- `o_valid`  output  1  `o_data` holds a finished sum.
- `i_accept`  input  1  downstream takes `o_data`.

## Operation
- **States.** There are two states:
  - ACC: `o_accept`=1, `o_valid`=0.
  - DONE: `o_accept`=0, `o_valid`=1.
- Both handshake outputs are decoded directly from the state register.
- **Input transfer.** A transfer occurs when `i_valid` and `o_accept` are both high.
  - The accumulator becomes `clamp(acc + sext(i_data))`.
  - The term counter increments.
- **Arithmetic.**
  - The sum is computed at `DATA_WIDTH_OUT+1` bits.
  - It is then clamped to [`-2^(DATA_WIDTH_OUT-1)`, `2^(DATA_WIDTH_OUT-1)-1`].
  - Any clamp sets the sticky overflow flag.
  - Accumulation continues from the clamped value.
  - When `DATA_WIDTH_OUT` is at least `DATA_WIDTH_IN + clog2(COUNT)`, the clamp can never fire.
- **ACC → DONE.** Taken on the transfer that makes the counter equal to `COUNT`.
  - The final clamped sum and the overflow flag are registered into `o_data` and `o_overflow`.
- **DONE → ACC.** Taken when `i_accept`=1.
  - Accumulator, counter and overflow flag are cleared.
  - `o_data` and `o_overflow` keep their values until the next block completes.
- **No input during DONE.** Input is stalled (`o_accept`=0) until the sum is taken, so a new block cannot start in the same cycle the old one is accepted.
- **Protocol rules.**
  - `i_valid` without `o_accept` is ignored, and `i_data` is not captured.
  - `i_accept` in ACC is ignored.
- **`i_clear`.** It takes priority over every transfer in the same cycle. From either state it:
  - clears accumulator, counter and overflow flag;
  - returns to ACC, which drops `o_valid` at the next edge;
  - drops the pending sum; `o_data` register contents are left unchanged.
- **`COUNT`=1.** Every accepted input produces a DONE; the output is `clamp(sext(i_data))`.
- **Reset (`i_nrst`=0).** Takes effect immediately, regardless of clock:
  - state ACC, so `o_accept`=1 and `o_valid`=0;
  - accumulator 0, counter 0;
  - `o_data`=0, `o_overflow`=0.
- **Reset mid-block.** Partial sums are discarded.

## Timing
- Input throughput is one term per cycle while in ACC.
- `o_valid` rises on the edge that captures the `COUNT`-th term: latency is 1 cycle from the last transfer.
- The minimum block period is `COUNT`+1 cycles, achieved when `i_accept` is held high.
- `o_data`, `o_overflow` and `o_valid` are registered.
- `o_accept` is a state decode with no combinational path from any input.

## Structure
- **Package `accumulator_signed_pkg`:**
  - state encoding constants ACC=1'b0, DONE=1'b1;
  - a `clog2` constant function used to size the counter and `DATA_WIDTH_OUT`.
- **Sub-module `saturate_signed`:**
  - combinational;
  - parameters `WIDTH_IN` and `WIDTH_OUT`;
  - input is the wide sum; outputs are the clamped value and an overflow bit;
  - reusable by the other signed arithmetic blocks.
- **Top level:** state register, counter of width `clog2(COUNT+1)`, accumulator, output registers.

## Test plan
- **Basic sum.** Defaults. Feed 3, -5, 7, 2 on consecutive cycles with `i_accept`=1 → `o_valid` one cycle after the last term, `o_data`=7, `o_overflow`=0, `o_accept` back high the cycle after.
- **Backpressure.** Hold `i_accept`=0 for 5 cycles after DONE while driving `i_valid`=1 with data 100 → `o_accept`=0 and `o_data` stable at the sum throughout; after accept, the next block starts from 0.
- **Saturation.** `DATA_WIDTH_IN`=8, `DATA_WIDTH_OUT`=8, `COUNT`=4. Feed 100, 100, -50, 10 → `o_data`=87 (127-50+10), `o_overflow`=1. Negative case: feed -128 four times → `o_data`=-128, `o_overflow`=1.
- **Clear.** Feed 2 terms, then pulse `i_clear` in the same cycle as `i_valid` → the third-cycle data is not accumulated; a fresh 4-term block of 1s gives 4.
- **Reset.** Drop `i_nrst` asynchronously in DONE and in mid-ACC → all outputs 0 and `o_accept`=1 immediately; a subsequent block sums correctly.
- **Gapped input.** `COUNT`=1 with random `i_valid` gaps → each accepted input is echoed sign-extended one cycle later. Full-width default with random data → the result matches the reference model exactly with `o_overflow`=0.

Source files
------------

// File: rtl/accumulator_signed_pkg.sv
// Shared types and helpers for the signed block accumulator.
// State encoding plus a constant clog2 used for sizing.
package accumulator_signed_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/saturate_signed.sv
// Clamps a wide signed value into a narrower signed range.
// Flags whenever the clamp changes the value.
module saturate_signed #(
  parameter int WIDTH_IN  = 19,
  parameter int WIDTH_OUT = 18
) (
  input  logic signed [WIDTH_IN-1:0]  sum_i,
  output logic signed [WIDTH_OUT-1:0] sat_o,
  output logic                        ovf_o
);

  logic [WIDTH_IN-WIDTH_OUT:0] top;

  // Fits only when all bits above the output sign agree with it
  assign top   = sum_i[WIDTH_IN-1:WIDTH_OUT-1];
  assign ovf_o = !((&top) || !(|top));

  always_comb begin
    sat_o = sum_i[WIDTH_OUT-1:0];
    if (ovf_o) begin
      sat_o = sum_i[WIDTH_IN-1] ? {1'b1, {(WIDTH_OUT-1){1'b0}}}
                                : {1'b0, {(WIDTH_OUT-1){1'b1}}};
    end
  end

endmodule

// File: rtl/accumulator_signed.sv
// Sums COUNT signed products into a saturating accumulator and
// hands each block sum downstream over a valid/accept handshake.
module accumulator_signed
  import accumulator_signed_pkg::*;
#(
  parameter int DATA_WIDTH_IN  = 16,
  parameter int COUNT          = 4,
  parameter int DATA_WIDTH_OUT = DATA_WIDTH_IN + clog2(COUNT)
) (
  input  logic                             i_clk,
  input  logic                             i_nrst,
  input  logic signed [DATA_WIDTH_IN-1:0]  i_data,
  input  logic                             i_valid,
  output logic                             o_accept,
  input  logic                             i_clear,
  output logic signed [DATA_WIDTH_OUT-1:0] o_data,
  output logic                             o_overflow,
  output logic                             o_valid,
  input  logic                             i_accept
);

  localparam int W  = DATA_WIDTH_OUT;
  localparam int CW = clog2(COUNT + 1);
  localparam int SW =
    ((W > DATA_WIDTH_IN) ? W : DATA_WIDTH_IN) + 1;

  state_e              state_q, state_d;
  logic signed [W-1:0] acc_q, acc_d;
  logic signed [W-1:0] data_q, data_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic                ovf_q, ovf_d;
  logic                oflow_q, oflow_d;

  logic signed [SW-1:0] sum;
  logic signed [W-1:0]  sat;
  logic                 sat_ovf;
  logic                 take, give, last;

  assign sum = SW'(acc_q) + SW'(i_data);

  saturate_signed #(
    .WIDTH_IN  (SW),
    .WIDTH_OUT (W)
  ) u_sat (
    .sum_i (sum),
    .sat_o (sat),
    .ovf_o (sat_ovf)
  );

  assign take = !i_clear && i_valid && (state_q == ACC);
  assign give = !i_clear && i_accept && (state_q == DONE);
  assign last = (cnt_q == CW'(COUNT - 1));

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    data_d  = data_q;
    oflow_d = oflow_q;
    unique case (1'b1)
      i_clear, give: begin
        state_d = ACC;
        acc_d   = '0;
        cnt_d   = '0;
        ovf_d   = 1'b0;
      end
      take: begin
        acc_d = sat;
        cnt_d = cnt_q + CW'(1);
        ovf_d = ovf_q | sat_ovf;
        if (last) begin
          state_d = DONE;
          data_d  = sat;
          oflow_d = ovf_q | sat_ovf;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= ACC;
      acc_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      data_q  <= '0;
      oflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      data_q  <= data_d;
      oflow_q <= oflow_d;
    end
  end

  assign o_accept   = (state_q == ACC);
  assign o_valid    = (state_q == DONE);
  assign o_data     = data_q;
  assign o_overflow = oflow_q;

endmodule

// File: tb/tb_accumulator_signed.sv
// Self-checking bench for accumulator_signed: default, saturating
// and single-term instances against a behavioural model.
module tb_accumulator_signed;

  logic clk  = 1'b0;
  logic nrst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [15:0] d_data;
  logic        d_valid, d_clear, d_accept;
  logic [17:0] d_odata;
  logic        d_ovf, d_oval, d_oacc;

  logic [7:0]  s_data;
  logic        s_valid, s_clear, s_accept;
  logic [7:0]  s_odata;
  logic        s_ovf, s_oval, s_oacc;

  logic [15:0] c_data;
  logic        c_valid, c_clear, c_accept;
  logic [15:0] c_odata;
  logic        c_ovf, c_oval, c_oacc;

  accumulator_signed #(.DATA_WIDTH_IN(16), .COUNT(4)) u_def (
    .i_clk(clk), .i_nrst(nrst), .i_data(d_data), .i_valid(d_valid),
    .o_accept(d_oacc), .i_clear(d_clear), .o_data(d_odata),
    .o_overflow(d_ovf), .o_valid(d_oval), .i_accept(d_accept));

  accumulator_signed #(.DATA_WIDTH_IN(8), .COUNT(4),
                       .DATA_WIDTH_OUT(8)) u_sat (
    .i_clk(clk), .i_nrst(nrst), .i_data(s_data), .i_valid(s_valid),
    .o_accept(s_oacc), .i_clear(s_clear), .o_data(s_odata),
    .o_overflow(s_ovf), .o_valid(s_oval), .i_accept(s_accept));

  accumulator_signed #(.DATA_WIDTH_IN(16), .COUNT(1)) u_c1 (
    .i_clk(clk), .i_nrst(nrst), .i_data(c_data), .i_valid(c_valid),
    .o_accept(c_oacc), .i_clear(c_clear), .o_data(c_odata),
    .o_overflow(c_ovf), .o_valid(c_oval), .i_accept(c_accept));

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic idle_all();
    d_data = '0; d_valid = 0; d_clear = 0; d_accept = 0;
    s_data = '0; s_valid = 0; s_clear = 0; s_accept = 0;
    c_data = '0; c_valid = 0; c_clear = 0; c_accept = 0;
  endtask

  task automatic test_reset();
    idle_all();
    #1 nrst = 0;
    #1;
    checks++; if (d_oacc !== 1'b1) begin failures++;
      $display("FAIL reset_accept got=%b exp=1", d_oacc); end
    checks++; if (d_oval !== 1'b0) begin failures++;
      $display("FAIL reset_valid got=%b exp=0", d_oval); end
    checks++; if (d_odata !== 18'd0) begin failures++;
      $display("FAIL reset_data got=%0d exp=0", d_odata); end
    checks++; if (d_ovf !== 1'b0) begin failures++;
      $display("FAIL reset_ovf got=%b exp=0", d_ovf); end
    checks++; if (s_oval !== 1'b0 || c_oval !== 1'b0) begin failures++;
      $display("FAIL reset_valid_others got=%b%b exp=00", s_oval, c_oval); end
    cyc();
    nrst = 1;
    cyc();
  endtask

  task automatic test_basic_sum();
    int vals[4] = '{3, -5, 7, 2};
    d_accept = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (d_oacc !== 1'b1) begin failures++;
        $display("FAIL basic_accept term=%0d got=%b exp=1", i, d_oacc); end
      d_valid = 1; d_data = 16'(vals[i]);
      cyc();
    end
    d_valid = 0;
    checks++; if (d_oval !== 1'b1) begin failures++;
      $display("FAIL basic_valid got=%b exp=1", d_oval); end
    checks++; if (d_odata !== 18'd7) begin failures++;
      $display("FAIL basic_data got=%0d exp=7", $signed(d_odata)); end
    checks++; if (d_ovf !== 1'b0) begin failures++;
      $display("FAIL basic_ovf got=%b exp=0", d_ovf); end
    checks++; if (d_oacc !== 1'b0) begin failures++;
      $display("FAIL basic_stall got=%b exp=0", d_oacc); end
    cyc();
    checks++; if (d_oval !== 1'b0 || d_oacc !== 1'b1) begin failures++;
      $display("FAIL basic_return got=%b%b exp=01", d_oval, d_oacc); end
    checks++; if (d_odata !== 18'd7) begin failures++;
      $display("FAIL basic_hold got=%0d exp=7", $signed(d_odata)); end
    d_accept = 0;
  endtask

  task automatic test_backpressure();
    int sum = 0;
    int v;
    d_accept = 0;
    for (int i = 0; i < 4; i++) begin
      v = int'($urandom_range(2000)) - 1000;
      sum += v;
      d_valid = 1; d_data = 16'(v);
      cyc();
    end
    d_data = 16'd100;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (d_oacc !== 1'b0 || d_oval !== 1'b1 || d_odata !== 18'(sum)) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d got acc=%b val=%b data=%0d exp 0 1 %0d",
                 k, d_oacc, d_oval, $signed(d_odata), sum);
      end
      cyc();
    end
    d_valid = 0; d_accept = 1;
    cyc();
    checks++; if (d_oval !== 1'b0) begin failures++;
      $display("FAIL bp_release got=%b exp=0", d_oval); end
    for (int i = 1; i <= 4; i++) begin
      d_valid = 1; d_data = 16'(i * 10);
      cyc();
    end
    d_valid = 0;
    checks++; if (d_odata !== 18'd100 || d_oval !== 1'b1) begin failures++;
      $display("FAIL bp_next got=%0d val=%b exp=100 1", $signed(d_odata), d_oval); end
    cyc();
    d_accept = 0;
  endtask

  task automatic test_clear();
    d_accept = 1;
    d_valid = 1; d_data = 16'd5; cyc();
    d_data = 16'd6; cyc();
    d_data = 16'd50; d_clear = 1; cyc();
    d_clear = 0;
    checks++; if (d_oacc !== 1'b1 || d_oval !== 1'b0) begin failures++;
      $display("FAIL clear_acc got=%b%b exp=10", d_oacc, d_oval); end
    for (int i = 0; i < 4; i++) begin
      d_data = 16'd1; cyc();
    end
    d_valid = 0;
    checks++; if (d_odata !== 18'd4 || d_oval !== 1'b1) begin failures++;
      $display("FAIL clear_fresh got=%0d val=%b exp=4 1", $signed(d_odata), d_oval); end
    cyc();
    d_accept = 0;
    for (int i = 0; i < 4; i++) begin
      d_valid = 1; d_data = 16'd7; cyc();
    end
    d_valid = 0; d_clear = 1; cyc();
    d_clear = 0;
    checks++;
    if (d_oval !== 1'b0 || d_oacc !== 1'b1 || d_odata !== 18'd28) begin
      failures++;
      $display("FAIL clear_done got val=%b acc=%b data=%0d exp 0 1 28",
               d_oval, d_oacc, $signed(d_odata));
    end
    d_accept = 1;
    for (int i = 0; i < 4; i++) begin
      d_valid = 1; d_data = 16'd1; cyc();
    end
    d_valid = 0;
    checks++; if (d_odata !== 18'd4 || d_oval !== 1'b1) begin failures++;
      $display("FAIL clear_after_done got=%0d val=%b exp=4 1", $signed(d_odata), d_oval); end
    cyc();
    d_accept = 0;
  endtask

  task automatic test_saturation();
    int blk[3][4] = '{'{100, 100, -50, 10}, '{-128, -128, -128, -128},
                      '{1, 2, 3, 4}};
    int ex[3] = '{87, -128, 10};
    bit eo[3] = '{1'b1, 1'b1, 1'b0};
    s_accept = 1;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 4; i++) begin
        s_valid = 1; s_data = 8'(blk[b][i]); cyc();
      end
      s_valid = 0;
      checks++;
      if (s_odata !== 8'(ex[b]) || s_ovf !== eo[b] || s_oval !== 1'b1) begin
        failures++;
        $display("FAIL sat_block%0d got=%0d ovf=%b val=%b exp=%0d ovf=%b",
                 b, $signed(s_odata), s_ovf, s_oval, ex[b], eo[b]);
      end
      cyc();
    end
    s_accept = 0;
  endtask

  task automatic test_sat_random();
    int acc;
    bit ov;
    s_accept = 1;
    for (int b = 0; b < 12; b++) begin
      acc = 0; ov = 0;
      for (int i = 0; i < 4; i++) begin
        s_valid = 1; s_data = 8'($urandom);
        acc += int'($signed(s_data));
        if (acc > 127) begin acc = 127; ov = 1; end
        else if (acc < -128) begin acc = -128; ov = 1; end
        cyc();
      end
      s_valid = 0;
      checks++;
      if (s_odata !== 8'(acc) || s_ovf !== ov) begin
        failures++;
        $display("FAIL sat_rand%0d got=%0d ovf=%b exp=%0d ovf=%b",
                 b, $signed(s_odata), s_ovf, acc, ov);
      end
      cyc();
    end
    s_accept = 0;
  endtask

  task automatic test_async_reset();
    d_accept = 0;
    for (int i = 0; i < 4; i++) begin
      d_valid = 1; d_data = 16'(int'($urandom_range(200)) + 1); cyc();
    end
    d_valid = 0;
    #2 nrst = 0;
    #1;
    checks++;
    if (d_oval !== 1'b0 || d_oacc !== 1'b1 || d_odata !== 18'd0 || d_ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_done got val=%b acc=%b data=%0d ovf=%b exp 0 1 0 0",
               d_oval, d_oacc, $signed(d_odata), d_ovf);
    end
    #1 nrst = 1;
    cyc();
    d_accept = 1;
    d_valid = 1; d_data = 16'd1000; cyc();
    d_data = 16'd2000; cyc();
    d_valid = 0;
    #2 nrst = 0;
    #1;
    checks++; if (d_oacc !== 1'b1 || d_oval !== 1'b0) begin failures++;
      $display("FAIL rst_mid got=%b%b exp=10", d_oacc, d_oval); end
    #1 nrst = 1;
    cyc();
    for (int i = 1; i <= 4; i++) begin
      d_valid = 1; d_data = 16'(i); cyc();
    end
    d_valid = 0;
    checks++; if (d_odata !== 18'd10 || d_oval !== 1'b1) begin failures++;
      $display("FAIL rst_after got=%0d val=%b exp=10 1", $signed(d_odata), d_oval); end
    cyc();
    d_accept = 0;
  endtask

  task automatic test_count1_gapped();
    bit pend = 0;
    logic [15:0] exp = '0;
    for (int n = 0; n < 60; n++) begin
      checks++;
      if (c_oacc !== !pend || c_oval !== pend) begin
        failures++;
        $display("FAIL c1_hs cyc=%0d got acc=%b val=%b exp pend=%b",
                 n, c_oacc, c_oval, pend);
      end
      if (pend) begin
        checks++;
        if (c_odata !== exp || c_ovf !== 1'b0) begin
          failures++;
          $display("FAIL c1_data cyc=%0d got=%0d ovf=%b exp=%0d",
                   n, $signed(c_odata), c_ovf, $signed(exp));
        end
      end
      c_valid  = 1'($urandom_range(1));
      c_data   = 16'($urandom);
      c_accept = ($urandom_range(3) != 0);
      if (pend) begin
        if (c_accept) pend = 0;
      end else if (c_valid) begin
        pend = 1; exp = c_data;
      end
      cyc();
    end
    c_valid = 0; c_accept = 1; cyc();
    c_accept = 0;
  endtask

  task automatic test_random_full();
    int q[$];
    longint exp = 0;
    bit pend = 0;
    for (int n = 0; n < 200; n++) begin
      checks++;
      if (d_oacc !== !pend || d_oval !== pend) begin
        failures++;
        $display("FAIL rnd_hs cyc=%0d got acc=%b val=%b exp pend=%b",
                 n, d_oacc, d_oval, pend);
      end
      if (pend) begin
        checks++;
        if (d_odata !== 18'(exp) || d_ovf !== 1'b0) begin
          failures++;
          $display("FAIL rnd_data cyc=%0d got=%0d ovf=%b exp=%0d",
                   n, $signed(d_odata), d_ovf, exp);
        end
      end
      d_valid  = ($urandom_range(3) != 0);
      d_data   = 16'($urandom);
      d_accept = 1'($urandom_range(1));
      if (pend) begin
        if (d_accept) pend = 0;
      end else if (d_valid) begin
        q.push_back(int'($signed(d_data)));
        if (q.size() == 4) begin
          exp = 0;
          foreach (q[k]) exp += longint'(q[k]);
          pend = 1;
          q.delete();
        end
      end
      cyc();
    end
    d_valid = 0; d_accept = 1; cyc();
    d_accept = 0;
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_backpressure();
    test_clear();
    test_saturation();
    test_sat_random();
    test_async_reset();
    test_count1_gapped();
    test_random_full();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
